// File: rtl/pid_hdng_ctrl.sv
// Pipelined heading PID: error register, P/I/D term stage, wheel-command stage.
// Optional macro PID_RAMP_EN replaces the forward speed with a ramped register.
module pid_hdng_ctrl #(
    parameter int HDNG_W    = 12,
    parameter int ESAT_W    = 10,
    parameter int INTG_W    = 16,
    parameter int SPD_W     = 11,
    parameter int D_DEPTH   = 2,
    parameter int AT_THR    = 30,
    parameter int RAMP_STEP = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     moving_i,
    input  logic signed [HDNG_W-1:0] dsrd_hdng_i,
    input  logic signed [HDNG_W-1:0] actl_hdng_i,
    input  logic                     hdng_vld_i,
    input  logic        [SPD_W-1:0]  frwrd_spd_i,
    input  logic        [3:0]        kp_i,
    input  logic        [4:0]        kd_i,
    output logic                     at_hdng_o,
    output logic signed [SPD_W:0]    lft_spd_o,
    output logic signed [SPD_W:0]    rght_spd_o,
    output logic                     spd_vld_o
);
    localparam int P_W   = ESAT_W + 5;
    localparam int I_W   = INTG_W - 4;
    localparam int D_W   = 14;
    localparam int PI_W  = (P_W > I_W) ? P_W : I_W;
    localparam int SUM_W = ((PI_W > D_W) ? PI_W : D_W) + 2;
    localparam int OUT_W = SPD_W + 1;
    localparam int CMD_W = ((SUM_W > OUT_W) ? SUM_W : OUT_W) + 2;
    localparam int EMAX  = (1 << (ESAT_W - 1)) - 1;
    localparam int EMIN  = -(1 << (ESAT_W - 1));
    localparam int OMAX  = (1 << SPD_W) - 1;
    localparam int OMIN  = -(1 << SPD_W);

    logic signed [HDNG_W-1:0] err_q;
    logic                     v0_q, v1_q;
    logic signed [INTG_W-1:0] integ_q;
    logic signed [ESAT_W-1:0] hist_q [D_DEPTH];
    logic signed [P_W-1:0]    p_q;
    logic signed [I_W-1:0]    i_q;
    logic signed [D_W-1:0]    d_q;
    logic                     at1_q;
    logic        [SPD_W-1:0]  fwd;

    logic signed [ESAT_W-1:0] err_sat;
    logic signed [INTG_W:0]   integ_sum;
    logic signed [INTG_W-1:0] integ_d;
    logic signed [ESAT_W:0]   dd_full;
    logic signed [7:0]        dd;
    logic signed [P_W-1:0]    p_d;
    logic signed [D_W-1:0]    d_d;
    logic                     at_d;
    logic signed [SUM_W-1:0]  sum;
    logic signed [SUM_W-1:0]  corr;
    logic signed [CMD_W-1:0]  lft_full, rght_full;
    logic signed [SPD_W:0]    lft_d, rght_d;

    always_comb begin
        err_sat = err_q[ESAT_W-1:0];
        if (err_q > EMAX)      err_sat = ESAT_W'(EMAX);
        else if (err_q < EMIN) err_sat = ESAT_W'(EMIN);

        integ_sum = (INTG_W+1)'(integ_q) + (INTG_W+1)'(err_sat);
        integ_d   = integ_sum[INTG_W-1:0];
        // Saturate instead of wrapping when the extra sign bit disagrees.
        if (integ_sum[INTG_W] != integ_sum[INTG_W-1])
            integ_d = {integ_sum[INTG_W], {(INTG_W-1){~integ_sum[INTG_W]}}};

        dd_full = (ESAT_W+1)'(err_sat) - (ESAT_W+1)'(hist_q[D_DEPTH-1]);
        dd      = dd_full[7:0];
        if (dd_full > 127)       dd = 8'sd127;
        else if (dd_full < -128) dd = -8'sd128;

        p_d  = err_sat * $signed({1'b0, kp_i});
        d_d  = dd * $signed({1'b0, kd_i});
        at_d = (err_sat < AT_THR) && (err_sat > -AT_THR);

        sum       = SUM_W'(p_q) + SUM_W'(i_q) + SUM_W'(d_q);
        corr      = sum >>> 3;
        lft_full  = CMD_W'($signed({1'b0, fwd})) + CMD_W'(corr);
        rght_full = CMD_W'($signed({1'b0, fwd})) - CMD_W'(corr);

        lft_d = lft_full[SPD_W:0];
        if (lft_full > OMAX)      lft_d = OUT_W'(OMAX);
        else if (lft_full < OMIN) lft_d = OUT_W'(OMIN);
        rght_d = rght_full[SPD_W:0];
        if (rght_full > OMAX)      rght_d = OUT_W'(OMAX);
        else if (rght_full < OMIN) rght_d = OUT_W'(OMIN);
    end

`ifdef PID_RAMP_EN
    logic [SPD_W-1:0] fwd_q;
    logic [SPD_W:0]   ramp_sum;

    assign fwd      = fwd_q;
    assign ramp_sum = {1'b0, fwd_q} + (SPD_W+1)'(RAMP_STEP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_q <= '0;
        end else if (!moving_i) begin
            fwd_q <= '0;
        end else if (v0_q) begin
            fwd_q <= (ramp_sum > {1'b0, frwrd_spd_i}) ? frwrd_spd_i : ramp_sum[SPD_W-1:0];
        end else if (frwrd_spd_i < fwd_q) begin
            fwd_q <= frwrd_spd_i;
        end
    end
`else
    assign fwd = frwrd_spd_i;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || !moving_i) begin
            err_q      <= '0;
            v0_q       <= 1'b0;
            v1_q       <= 1'b0;
            integ_q    <= '0;
            p_q        <= '0;
            i_q        <= '0;
            d_q        <= '0;
            at1_q      <= 1'b0;
            at_hdng_o  <= 1'b0;
            lft_spd_o  <= '0;
            rght_spd_o <= '0;
            spd_vld_o  <= 1'b0;
            for (int k = 0; k < D_DEPTH; k++) hist_q[k] <= '0;
        end else begin
            v0_q <= hdng_vld_i;
            if (hdng_vld_i) err_q <= actl_hdng_i - dsrd_hdng_i;

            v1_q <= v0_q;
            if (v0_q) begin
                integ_q <= integ_d;
                p_q     <= p_d;
                i_q     <= integ_d[INTG_W-1:4];
                d_q     <= d_d;
                at1_q   <= at_d;
                hist_q[0] <= err_sat;
                for (int k = 1; k < D_DEPTH; k++) hist_q[k] <= hist_q[k-1];
            end

            spd_vld_o <= v1_q;
            if (v1_q) begin
                lft_spd_o  <= lft_d;
                rght_spd_o <= rght_d;
                at_hdng_o  <= at1_q;
            end
        end
    end
endmodule

// File: doc/pid_hdng_ctrl.md
# pid_hdng_ctrl

Parametrised, pipelined heading-PID controller for the differential-drive chassis. Computes signed heading error on each `hdng_vld` sample, forms P/I/D terms with run-time gains, and drives left/right wheel speed commands with an output-valid strobe. Sits between the heading estimator and the motor PWM/drive block; supersedes the fixed-width, fixed-gain PID.

## Interface
- `HDNG_W`, 12: signed heading width.
- `ESAT_W`, 10: saturated-error width.
- `INTG_W`, 16: integrator width; I term = integrator >>> 4.
- `SPD_W`, 11: unsigned forward-speed width; outputs are signed `SPD_W+1`.
- `D_DEPTH`, 2: D term spans `D_DEPTH` valid samples (history depth, ≥1).
- `AT_THR`, 30: `at_hdng` threshold on |err_sat|.
- `RAMP_STEP`, 16: ramp increment per valid sample (used only with `PID_RAMP_EN`).

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `moving` in 1: 0 forces outputs to 0 and clears integrator, D history, ramp and pipeline.
- `dsrd_hdng` in `HDNG_W` signed: desired heading.
- `actl_hdng` in `HDNG_W` signed: measured heading.
- `hdng_vld` in 1: one-cycle strobe; the heading pair is valid this cycle.
- `frwrd_spd` in `SPD_W`: unsigned forward speed.
- `kp` in 4: unsigned P gain.
- `kd` in 5: unsigned D gain.
- `at_hdng` out 1: registered, |err_sat| < `AT_THR`.
- `lft_spd`, `rght_spd` out `SPD_W+1` signed: wheel commands.
- `spd_vld` out 1: one-cycle pulse when the outputs update.

## Operation
- Stage 0 (edge E0, `hdng_vld`=1): register `err = actl_hdng - dsrd_hdng` (wraps at `HDNG_W`) and a valid bit.
- Stage 1 (E1):
  - Clamp `err` to signed `ESAT_W` to form `err_sat`.
  - `P = err_sat * kp`.
  - Integrator += `err_sat`, clamped to the signed `INTG_W` range; no wrap, no freeze.
  - I = post-update integrator >>> 4.
  - `dd = err_sat - hist[D_DEPTH-1]`, clamped to signed 8 bits; `D = dd * kd`.
  - History shifts in `err_sat`. P, I, D and at_hdng are registered.
- Stage 2 (E2):
  - `sum = P + I + D`, sign-extended with no overflow; `corr = sum >>> 3`.
  - `lft = fwd + corr`, `rght = fwd - corr`, each clamped to signed `SPD_W+1`.
  - `lft`, `rght` and `at_hdng` are registered; `spd_vld` pulses.
- Integrator, history and outputs change only on valid samples. Between samples, outputs hold.
- `moving`=0:
  - On the next edge, integrator, history, ramp, pipeline valids and outputs go to 0.
  - In-flight samples are dropped, with no `spd_vld`.
  - `moving` rising restarts from zero state.
- `kp` and `kd` are sampled at Stage 1. Changing them mid-stream affects subsequent samples only.

## Timing
- Reset values: `lft_spd`=0, `rght_spd`=0, `at_hdng`=0, `spd_vld`=0. Integrator, history and ramp are 0.
- Latency: `hdng_vld` sampled at E0 gives `spd_vld` high in the cycle after E2 (3 edges).
- `hdng_vld` on every cycle is supported, giving one `spd_vld` per sample in order.
- Reset asserted mid-pipeline clears all stages immediately.

## Configuration
- `PID_RAMP_EN` defined: effective `fwd` is a register. It clears when `moving`=0, and on each Stage-1 valid sample becomes `min(fwd + RAMP_STEP, frwrd_spd)`. If `frwrd_spd` drops below `fwd`, it snaps down to `frwrd_spd`.
- `PID_RAMP_EN` undefined: `fwd = frwrd_spd` directly, with no ramp register.

## Test plan
- Defaults, `PID_RAMP_EN` off. After reset: `moving`=1, `dsrd`=0, `actl`=32, `kp`=3, `kd`=14, `frwrd`=0x100, one `hdng_vld`. Expect `spd_vld` 3 edges later, `lft_spd`=0x144, `rght_spd`=0x0BC, `at_hdng`=0.
- `actl`=20, `dsrd`=0, repeated samples -> `at_hdng`=1. `actl`=-30 -> `at_hdng`=0.
- `actl`=0x7FF, `dsrd`=0 every cycle -> `err_sat`=511. After 64 samples the integrator is 32704; the 65th and later samples hold it at 32767.
- `frwrd`=0x7FF with large positive error -> `lft_spd`=2047 (clamped), `rght_spd`=2047-corr.
- Drop `moving` one cycle after `hdng_vld`. Expect no `spd_vld`, outputs 0, and the integrator 0 on the next edge.
- `PID_RAMP_EN`, `RAMP_STEP`=16, error 0, `frwrd`=0x100. Successive `lft_spd` values are 16, 32, … 256, then 256 holds.
